// File: rtl/eth_int_dispatcher_pkg.sv
// eth_int_dispatcher shared definitions
// register map, status codes, state encodings
package eth_int_dispatcher_pkg;

  localparam logic [7:0]  ISR_OFS    = 8'h92;
  localparam logic [7:0]  IER_OFS    = 8'h90;
  localparam logic [7:0]  RXFCTR_OFS = 8'h9C;
  localparam logic [15:0] IER_VAL    = 16'hE000;
  localparam logic [3:0]  REG_IDLE   = 4'd0;
  localparam logic [1:0]  ST_DONE    = 2'b11;
  localparam logic [1:0]  ST_ERR     = 2'b10;

  localparam int RXIS = 13;
  localparam int TXIS = 14;
  localparam int LCIS = 15;

  typedef enum logic [1:0] {
    MST_INIT,
    MST_TRANS,
    MST_RECV,
    MST_DISP
  } mst_sel_e;

  typedef enum logic [3:0] {
    S_WAIT_INIT,
    S_IDLE,
    S_MASK,
    S_RD_ISR,
    S_ACK,
    S_RD_CNT,
    S_RX_SVC,
    S_TX_SVC,
    S_UNMASK
  } disp_st_e;

  typedef enum logic [1:0] {
    A_IDLE,
    A_LEAVE,
    A_BACK
  } acc_st_e;

  function automatic logic is_fin(input logic [1:0] s);
    return (s == ST_DONE) || (s == ST_ERR);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/eth_int_dispatcher_if.sv
// eth_int_dispatcher register bus
// master drives commands, slave returns engine state
interface eth_int_dispatcher_if;
  logic [7:0]  offset;
  logic        length;
  logic        wr;
  logic [15:0] write_data;
  logic        new_command;
  logic        own_bus;
  logic [3:0]  reg_state;
  logic [15:0] read_data;

  modport master (
    output offset, length, wr, write_data,
    output new_command, own_bus,
    input  reg_state, read_data
  );

  modport slave (
    input  offset, length, wr, write_data,
    input  new_command, own_bus,
    output reg_state, read_data
  );
endinterface

// File: rtl/eth_reg_access.sv
// eth_reg_access: one register cycle on the bus
// issue, wait engine busy, wait idle, capture, done
module eth_reg_access
  import eth_int_dispatcher_pkg::*;
(
  input  logic        clk40m,
  input  logic        RSTN,
  input  logic        abort,
  input  logic        start,
  input  logic [7:0]  acc_ofs,
  input  logic        acc_wr,
  input  logic [15:0] acc_wdata,
  output logic        done,
  output logic [15:0] rdata,
  eth_int_dispatcher_if.master bus
);

  acc_st_e st;

  // access sequencer with registered bus outputs
  always_ff @(posedge clk40m or negedge RSTN) begin
    if (!RSTN) begin
      st              <= A_IDLE;
      bus.offset      <= '0;
      bus.length      <= 1'b0;
      bus.wr          <= 1'b0;
      bus.write_data  <= '0;
      bus.new_command <= 1'b0;
      bus.own_bus     <= 1'b0;
      done            <= 1'b0;
      rdata           <= '0;
    end else begin
      bus.new_command <= 1'b0;
      done            <= 1'b0;
      if (abort) begin
        st          <= A_IDLE;
        bus.own_bus <= 1'b0;
      end else begin
        unique case (st)
          A_IDLE: if (start) begin
            bus.offset      <= acc_ofs;
            bus.length      <= 1'b1;
            bus.wr          <= acc_wr;
            bus.write_data  <= acc_wdata;
            bus.new_command <= 1'b1;
            bus.own_bus     <= 1'b1;
            st              <= A_LEAVE;
          end
          A_LEAVE: if (bus.reg_state != REG_IDLE)
            st <= A_BACK;
          A_BACK: if (bus.reg_state == REG_IDLE) begin
            rdata       <= bus.read_data;
            done        <= 1'b1;
            bus.own_bus <= 1'b0;
            st          <= A_IDLE;
          end
          default: st <= A_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/eth_int_dispatcher.sv
// eth_int_dispatcher: KSZ8851 interrupt service
// sequences mask/ack/rx/tx/unmask over masters
module eth_int_dispatcher
  import eth_int_dispatcher_pkg::*;
(
  input  logic       clk40m,
  input  logic       RSTN,
  input  logic       init_done,
  input  logic       INTRN,
  input  logic       tx_req,
  eth_int_dispatcher_if.master bus,
  output logic       recv_en,
  input  logic [1:0] recv_status,
  output logic       trans_en,
  input  logic [1:0] trans_status,
  output logic       link_change,
  output logic [7:0] err_cnt
);

  disp_st_e    st;
  logic [1:0]  int_sync;
  logic        int_l;
  logic        tx_pend;
  logic        tx_clr;
  logic [7:0]  frames;
  logic [15:0] isr;
  logic        issued;
  logic        from_int;
  logic        rx_gap;
  logic        acc_state;
  logic        acc_start;
  logic        acc_done;
  logic [15:0] acc_rdata;
  logic [7:0]  acc_ofs;
  logic        acc_wr;
  logic [15:0] acc_wdata;

  assign int_l  = ~int_sync[1];
  assign tx_clr = (st == S_TX_SVC) && trans_en
                  && is_fin(trans_status);

  // two-flop synchronizer for the chip interrupt
  always_ff @(posedge clk40m or negedge RSTN) begin
    if (!RSTN) int_sync <= 2'b11;
    else       int_sync <= {int_sync[0], INTRN};
  end

  // pending transmit request
  always_ff @(posedge clk40m or negedge RSTN) begin
    if (!RSTN)          tx_pend <= 1'b0;
    else if (!init_done) tx_pend <= 1'b0;
    else tx_pend <= tx_req | (tx_pend & ~tx_clr);
  end

  // command fields for the register states
  always_comb begin
    acc_state = 1'b0;
    acc_ofs   = IER_OFS;
    acc_wr    = 1'b1;
    acc_wdata = '0;
    unique case (st)
      S_MASK:   acc_state = 1'b1;
      S_RD_ISR: begin
        acc_state = 1'b1;
        acc_ofs   = ISR_OFS;
        acc_wr    = 1'b0;
      end
      S_ACK: begin
        acc_state = 1'b1;
        acc_ofs   = ISR_OFS;
        acc_wdata = isr;
      end
      S_RD_CNT: begin
        acc_state = 1'b1;
        acc_ofs   = RXFCTR_OFS;
        acc_wr    = 1'b0;
      end
      S_UNMASK: begin
        acc_state = 1'b1;
        acc_wdata = IER_VAL;
      end
      default: ;
    endcase
    acc_start = acc_state & ~issued;
  end

  eth_reg_access u_acc (
    .clk40m    (clk40m),
    .RSTN      (RSTN),
    .abort     (~init_done),
    .start     (acc_start),
    .acc_ofs   (acc_ofs),
    .acc_wr    (acc_wr),
    .acc_wdata (acc_wdata),
    .done      (acc_done),
    .rdata     (acc_rdata),
    .bus       (bus)
  );

  // service sequencer with registered enables
  always_ff @(posedge clk40m or negedge RSTN) begin
    if (!RSTN) begin
      st          <= S_WAIT_INIT;
      issued      <= 1'b0;
      from_int    <= 1'b0;
      rx_gap      <= 1'b0;
      frames      <= '0;
      isr         <= '0;
      recv_en     <= 1'b0;
      trans_en    <= 1'b0;
      link_change <= 1'b0;
      err_cnt     <= '0;
    end else begin
      link_change <= 1'b0;
      if (acc_start) issued <= 1'b1;
      if (!init_done) begin
        st       <= S_WAIT_INIT;
        recv_en  <= 1'b0;
        trans_en <= 1'b0;
        issued   <= 1'b0;
        rx_gap   <= 1'b0;
      end else begin
        unique case (st)
          S_WAIT_INIT: st <= S_IDLE;
          S_IDLE: begin
            if (int_l) begin
              st <= S_MASK;
            end else if (tx_pend) begin
              st       <= S_TX_SVC;
              from_int <= 1'b0;
            end
          end
          S_MASK: if (acc_done) begin
            issued <= 1'b0;
            st     <= S_RD_ISR;
          end
          S_RD_ISR: if (acc_done) begin
            issued <= 1'b0;
            isr    <= acc_rdata;
            st     <= (acc_rdata == 16'h0) ? S_UNMASK : S_ACK;
          end
          S_ACK: if (acc_done) begin
            issued      <= 1'b0;
            link_change <= isr[LCIS];
            if (isr[RXIS]) begin
              st <= S_RD_CNT;
            end else if (isr[TXIS] || tx_pend) begin
              st       <= S_TX_SVC;
              from_int <= 1'b1;
            end else begin
              st <= S_UNMASK;
            end
          end
          S_RD_CNT: if (acc_done) begin
            issued <= 1'b0;
            frames <= acc_rdata[15:8];
            rx_gap <= 1'b0;
            if (acc_rdata[15:8] != 8'd0) begin
              st <= S_RX_SVC;
            end else if (tx_pend) begin
              st       <= S_TX_SVC;
              from_int <= 1'b1;
            end else begin
              st <= S_UNMASK;
            end
          end
          S_RX_SVC: begin
            if (rx_gap) begin
              if (frames == 8'd0) begin
                if (tx_pend) begin
                  st       <= S_TX_SVC;
                  from_int <= 1'b1;
                end else begin
                  st <= S_UNMASK;
                end
              end else begin
                rx_gap  <= 1'b0;
                recv_en <= 1'b1;
              end
            end else if (!recv_en) begin
              recv_en <= 1'b1;
            end else if (is_fin(recv_status)) begin
              recv_en <= 1'b0;
              rx_gap  <= 1'b1;
              if (recv_status == ST_ERR) begin
                err_cnt <= sat_inc(err_cnt);
                frames  <= 8'd0;
              end else begin
                frames <= frames - 8'd1;
              end
            end
          end
          S_TX_SVC: begin
            if (!trans_en) begin
              trans_en <= 1'b1;
            end else if (is_fin(trans_status)) begin
              trans_en <= 1'b0;
              if (trans_status == ST_ERR)
                err_cnt <= sat_inc(err_cnt);
              st <= from_int ? S_UNMASK : S_IDLE;
            end
          end
          S_UNMASK: if (acc_done) begin
            issued <= 1'b0;
            st     <= S_IDLE;
          end
          default: st <= S_WAIT_INIT;
        endcase
      end
    end
  end

endmodule
